// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

   // Loader states. S_CSUM is reachable only in checksum builds.
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_DONE
   } state_t;

   localparam int HDR_BYTES   = 2;  // 16-bit little-endian word count
   localparam int WORD_BYTES  = 4;  // bytes per instruction word
   localparam int WORD_STRIDE = 4;  // byte-address step between words

endpackage

// File: rtl/imem_loader_packer.sv
// byte_to_word_packer: assembles little-endian bytes into 32-bit words.
// Lane 0 fills bits [7:0]; the byte on the last lane completes the word, which
// is presented on the next cycle with a one-cycle word_valid. The lane is
// retained indefinitely while byte_valid is low.
module byte_to_word_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic [7:0]  byte_data,
   input  logic        byte_valid,
   output logic [1:0]  lane,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [1:0] LAST_LANE = 2'(WORD_BYTES - 1);

   logic [23:0] partial;

   // Collect lanes 0..2, then emit the full word when the last lane arrives.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         lane       <= '0;
         partial    <= '0;
         word       <= '0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= 1'b0;
         if (clear) begin
            lane    <= '0;
            partial <= '0;
         end else if (byte_valid) begin
            if (lane == LAST_LANE) begin
               word       <= {byte_data, partial};
               word_valid <= 1'b1;
               lane       <= '0;
            end else begin
               case (lane)
                  2'd0:    partial[7:0]   <= byte_data;
                  2'd1:    partial[15:8]  <= byte_data;
                  default: partial[23:16] <= byte_data;
               endcase
               lane <= lane + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program image (16-bit word count, then little-endian
// words) into the instruction memory while holding the CPU in reset.
// Build option: define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte covering the header and all data bytes.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int                IMEM_DEPTH = 1024,
   parameter int                ADDR_W     = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_hold,
   output logic              done,
   output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t END_STATE = S_CSUM;
`else
   localparam state_t END_STATE = S_DONE;
`endif

   state_t      state, next_state;
   logic [15:0] n_words;
   logic [15:0] word_cnt;
   logic        ovf_q;
   logic [1:0]  lane;
   logic        word_valid;
   logic        start_go;
   logic        accept;
   logic        data_accept;
   logic        word_end;
   logic        last_word;
   logic        word_ovf;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign start_go    = load_start && (state == S_IDLE || state == S_DONE);
   assign accept      = in_valid && in_ready;
   assign data_accept = accept && (state == S_DATA);
   assign word_end    = data_accept && (lane == 2'(WORD_BYTES - 1));
   assign last_word   = word_end && (word_cnt == n_words - 16'd1);
   assign word_ovf    = {16'd0, word_cnt} >= 32'(IMEM_DEPTH);

   // Words past the end of the memory are consumed but never written.
   assign imem_we = word_valid && !ovf_q;

   byte_to_word_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .clear      (start_go),
      .byte_data  (in_data),
      .byte_valid (data_accept),
      .lane       (lane),
      .word       (imem_wdata),
      .word_valid (word_valid)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   // Next-state decode plus state-derived handshake/status outputs.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      next_state = state;
      in_ready   = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: if (start_go) next_state = S_HDR0;
         S_HDR0: begin
            in_ready = 1'b1;
            if (accept) next_state = S_HDR1;
         end
         S_HDR1: begin
            in_ready = 1'b1;
            if (accept) next_state = ({in_data, n_words[7:0]} == 16'd0) ? END_STATE : S_DATA;
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (last_word) next_state = END_STATE;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            in_ready = 1'b1;
            if (accept) next_state = S_DONE;
         end
`endif
         S_DONE: begin
            done = 1'b1;
            if (start_go) next_state = S_HDR0;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Header capture, word counting, address generation, error and CPU hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_words      <= '0;
         word_cnt     <= '0;
         ovf_q        <= 1'b0;
         imem_addr    <= BASE_ADDR;
         err          <= 1'b0;
         cpu_rst_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else if (start_go) begin
         n_words      <= '0;
         word_cnt     <= '0;
         ovf_q        <= 1'b0;
         imem_addr    <= BASE_ADDR;
         err          <= 1'b0;
         cpu_rst_hold <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         if (accept && state == S_HDR0) n_words[7:0]  <= in_data;
         if (accept && state == S_HDR1) n_words[15:8] <= in_data;
         if (word_end) begin
            word_cnt <= word_cnt + 16'd1;
            ovf_q    <= word_ovf;
            if (word_ovf) err <= 1'b1;
         end
         if (word_valid) imem_addr <= imem_addr + ADDR_W'(WORD_STRIDE);
         // The final write lands in the first DONE cycle; release the CPU after it.
         if (state == S_DONE) cpu_rst_hold <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (accept && state != S_CSUM) csum <= csum ^ in_data;
         if (accept && state == S_CSUM && in_data != csum) err <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader (small IMEM_DEPTH to reach overflow).
// Expected writes are queued as bytes are driven and popped by a write monitor.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst_hold;
   logic        done;
   logic        err;

   int  total    = 0;
   int  bad      = 0;
   int  we_count = 0;
   wr_t exp_q[$];
   wr_t mon_e;

   imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_start   (load_start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .cpu_rst_hold (cpu_rst_hold),
      .done         (done),
      .err          (err)
   );

   always #5 clk = ~clk;

   // Write monitor: every write strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && imem_we) begin
         we_count++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL write_unexpected: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if ({imem_addr, imem_wdata} !== {mon_e.addr, mon_e.data}) begin
               bad++;
               $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                        imem_addr, imem_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   // Offer one byte until accepted (bounded); optionally idle one cycle after.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      bit rdy;
      int waited = 0;
      in_data  = b;
      in_valid = 1'b1;
      forever begin
         rdy = in_ready;
         step();
         if (rdy) break;
         waited++;
         if (waited > 20) begin
            total++;
            bad++;
            $display("FAIL byte_timeout: got in_ready=0 for 20 cycles, expected 1");
            break;
         end
      end
      in_valid = 1'b0;
      if (gap) step();
   endtask

   task automatic send_word(input logic [31:0] w, input int k, input bit gap);
      logic [31:0] wv;
      wv = w;
      for (int l = 0; l < WORD_BYTES; l++) begin
         if (l == WORD_BYTES - 1 && k < DEPTH) exp_q.push_back('{addr: 32'(4 * k), data: w});
         send_byte(wv[8*l +: 8], gap);
      end
   endtask

   // Full load: start pulse, header, words, and the checksum byte when enabled.
   // csum_force[8] set sends csum_force[7:0] instead of the computed checksum.
   task automatic load_image(input logic [15:0] n, input logic [31:0] w [8],
                             input bit gap, input logic [8:0] csum_force);
      logic [7:0]  x;
      logic [15:0] nv;
      x  = 8'h00;
      nv = n;
      pulse_start();
      for (int i = 0; i < HDR_BYTES; i++) begin
         x ^= nv[8*i +: 8];
         send_byte(nv[8*i +: 8], gap);
      end
      for (int k = 0; k < int'(n); k++) begin
         x ^= w[k][7:0] ^ w[k][15:8] ^ w[k][23:16] ^ w[k][31:24];
         send_word(w[k], k, gap);
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(csum_force[8] ? csum_force[7:0] : x, 1'b0);
`else
      if (csum_force[8]) x = csum_force[7:0];
`endif
   endtask

   task automatic wait_done();
      int n = 0;
      while (done !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL done_timeout: got done=%b, expected 1", done);
      end
      repeat (2) step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      total++;
      if ({in_ready, imem_we, cpu_rst_hold, done, err} !== 5'b00100) begin
         bad++;
         $display("FAIL reset_flags: got rdy/we/hold/done/err=%b, expected 00100",
                  {in_ready, imem_we, cpu_rst_hold, done, err});
      end
      total++;
      if ({imem_addr, imem_wdata} !== 64'h0) begin
         bad++;
         $display("FAIL reset_bus: got addr=%h data=%h, expected 0/0", imem_addr, imem_wdata);
      end
      step();
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'hAA;
      repeat (2) step();
      in_valid = 1'b0;
      total++;
      if ({in_ready, cpu_rst_hold, done} !== 3'b010) begin
         bad++;
         $display("FAIL idle_hold: got rdy/hold/done=%b, expected 010", {in_ready, cpu_rst_hold, done});
      end
   endtask

   task automatic test_basic(input bit gap);
      logic [31:0] w [8];
      int base;
      w    = '{32'h00100513, 32'h0000006F, 0, 0, 0, 0, 0, 0};
      base = we_count;
      load_image(16'd2, w, gap, 9'h000);
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (!gap) begin
         total++;
         if ({imem_we, done, cpu_rst_hold} !== 3'b111) begin
            bad++;
            $display("FAIL last_write_cycle: got we/done/hold=%b, expected 111", {imem_we, done, cpu_rst_hold});
         end
         step();
         total++;
         if ({imem_we, done, cpu_rst_hold, err} !== 4'b0100) begin
            bad++;
            $display("FAIL release_cycle: got we/done/hold/err=%b, expected 0100",
                     {imem_we, done, cpu_rst_hold, err});
         end
      end
`endif
      wait_done();
      total++;
      if ({done, cpu_rst_hold, err} !== 3'b100) begin
         bad++;
         $display("FAIL basic_final: got done/hold/err=%b, expected 100", {done, cpu_rst_hold, err});
      end
      total++;
      if (we_count - base != 2 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL basic_writes: got %0d writes (%0d pending), expected 2 (0)",
                  we_count - base, exp_q.size());
      end
   endtask

   task automatic test_zero_words();
      logic [31:0] w [8];
      int base;
      w    = '{default: 32'h0};
      base = we_count;
      load_image(16'd0, w, 1'b0, 9'h000);
`ifndef IMEM_LOADER_CHECKSUM_EN
      total++;
      if ({done, in_ready, imem_we} !== 3'b100) begin
         bad++;
         $display("FAIL zero_done: got done/rdy/we=%b, expected 100", {done, in_ready, imem_we});
      end
      step();
      total++;
      if (cpu_rst_hold !== 1'b0) begin
         bad++;
         $display("FAIL zero_release: got hold=%b, expected 0", cpu_rst_hold);
      end
`endif
      wait_done();
      total++;
      if (we_count != base || err !== 1'b0) begin
         bad++;
         $display("FAIL zero_writes: got %0d writes err=%b, expected 0 writes err=0", we_count - base, err);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] w [8];
      int base;
      w    = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
               32'h55555555, 32'h66666666, 0, 0};
      base = we_count;
      load_image(16'd6, w, 1'b0, 9'h000);
      wait_done();
      total++;
      if (we_count - base != DEPTH || exp_q.size() != 0) begin
         bad++;
         $display("FAIL ovf_writes: got %0d writes (%0d pending), expected %0d (0)",
                  we_count - base, exp_q.size(), DEPTH);
      end
      total++;
      if ({done, err, cpu_rst_hold} !== 3'b110) begin
         bad++;
         $display("FAIL ovf_flags: got done/err/hold=%b, expected 110", {done, err, cpu_rst_hold});
      end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] w [8];
      pulse_start();
      send_byte(8'h03, 1'b0);
      send_byte(8'h00, 1'b0);
      send_word(32'hCAFE0001, 0, 1'b0);
      send_word(32'hCAFE0002, 1, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      step();
      total++;
      if ({in_ready, imem_we, cpu_rst_hold, done, err} !== 5'b00100 || {imem_addr, imem_wdata} !== 64'h0) begin
         bad++;
         $display("FAIL midload_reset: got rdy/we/hold/done/err=%b addr=%h data=%h, expected 00100 0 0",
                  {in_ready, imem_we, cpu_rst_hold, done, err}, imem_addr, imem_wdata);
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL midload_pending: got %0d queued writes, expected 0", exp_q.size());
      end
      exp_q.delete();
      rst = 1'b0;
      step();
      w = '{32'h00100513, 32'h0000006F, 0, 0, 0, 0, 0, 0};
      load_image(16'd2, w, 1'b0, 9'h000);
      wait_done();
      total++;
      if (exp_q.size() != 0 || {done, err, cpu_rst_hold} !== 3'b100) begin
         bad++;
         $display("FAIL reload: got %0d pending done/err/hold=%b, expected 0 100",
                  exp_q.size(), {done, err, cpu_rst_hold});
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_checksum();
      logic [31:0] w [8];
      w = '{32'h00000013, 0, 0, 0, 0, 0, 0, 0};
      load_image(16'd1, w, 1'b0, 9'h112);
      wait_done();
      total++;
      if ({done, err, cpu_rst_hold} !== 3'b100) begin
         bad++;
         $display("FAIL csum_good: got done/err/hold=%b, expected 100", {done, err, cpu_rst_hold});
      end
      load_image(16'd1, w, 1'b0, 9'h100);
      wait_done();
      total++;
      if ({done, err, cpu_rst_hold} !== 3'b110) begin
         bad++;
         $display("FAIL csum_bad: got done/err/hold=%b, expected 110", {done, err, cpu_rst_hold});
      end
   endtask
`endif

   initial begin
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      test_reset();
      test_basic(1'b0);
      test_basic(1'b1);
      test_zero_words();
      test_overflow();
      test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
